// File: rtl/riscv_pkg.sv
// Shared fetch-side types and constants for the RV32I core.
// Redirect ranks let a pending redirect be compared against a newer one.
package riscv_pkg;

  typedef enum logic [1:0] {
    RESET = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC  = 32'h0000_0010;

  // A misaligned jump/branch target becomes a trap, so it ranks with trap.
  function automatic logic [1:0] redirect_rank(input logic trap, input logic jmp,
                                               input logic br, input logic misalign);
    logic [1:0] rank;
    if (trap || misalign) begin
      rank = 2'd3;
    end else if (jmp) begin
      rank = 2'd2;
    end else if (br) begin
      rank = 2'd1;
    end else begin
      rank = 2'd0;
    end
    return rank;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Combinational redirect priority mux: trap > jmp > br_taken, with the
// misaligned-target check folding bad targets onto TRAP_VEC.
module next_pc_sel #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(riscv_pkg::TRAP_VEC)
) (
  input  logic             trap,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  output logic [WIDTH-1:0] target,
  output logic             redirect,
  output logic             misalign
);

  always_comb begin
    target   = TRAP_VEC;
    redirect = 1'b0;
    misalign = 1'b0;
    if (trap) begin
      redirect = 1'b1;
    end else if (jmp) begin
      redirect = 1'b1;
      if (jmp_target[1:0] != 2'b00) begin
        misalign = 1'b1;
      end else begin
        target = jmp_target;
      end
    end else if (br_taken) begin
      redirect = 1'b1;
      if (br_target[1:0] != 2'b00) begin
        misalign = 1'b1;
      end else begin
        target = br_target;
      end
    end else begin
      redirect = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC register load, the imem req/ack handshake,
// and resolves redirects against stalls and outstanding fetches.
module fetch_ctrl #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(riscv_pkg::RESET_VEC),
  parameter logic [WIDTH-1:0] TRAP_VEC  = WIDTH'(riscv_pkg::TRAP_VEC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_cur,
  output logic             pc_en,
  output logic [WIDTH-1:0] pc_next,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic [WIDTH-1:0] jmp_target,
  input  logic             trap,
  output logic             fetch_valid,
  output logic             flush,
  output logic             misalign
);
  import riscv_pkg::*;

  fetch_state_t     state_q, state_d;
  logic             pend_vld_q, pend_vld_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic [1:0]       pend_rank_q, pend_rank_d;

  logic [WIDTH-1:0] sel_target;
  logic             sel_redirect;
  logic             sel_misalign;
  logic [1:0]       sel_rank;
  logic             use_pend;
  logic             eff_redirect;
  logic [WIDTH-1:0] eff_target;
  logic [WIDTH-1:0] pc_seq;

  next_pc_sel #(
    .WIDTH    (WIDTH),
    .TRAP_VEC (TRAP_VEC)
  ) u_next_pc_sel (
    .trap       (trap),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .target     (sel_target),
    .redirect   (sel_redirect),
    .misalign   (sel_misalign)
  );

  assign sel_rank = redirect_rank(trap, jmp, br_taken, sel_misalign);
  assign pc_seq   = pc_cur + WIDTH'(32'd4);

  // A pending redirect wins on ack unless a same-or-higher-rank one arrives that cycle.
  assign use_pend     = pend_vld_q && ((sel_rank == 2'd0) || (pend_rank_q > sel_rank));
  assign eff_redirect = sel_redirect || pend_vld_q;
  assign eff_target   = use_pend ? pend_tgt_q : sel_target;

  // Next-state and output decode.
  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_tgt_d  = pend_tgt_q;
    pend_rank_d = pend_rank_q;
    pc_en       = 1'b0;
    pc_next     = pc_seq;
    imem_req    = 1'b0;
    fetch_valid = 1'b0;
    flush       = sel_redirect;
    misalign    = sel_misalign;
    if (rst) begin
      state_d    = RESET;
      pend_vld_d = 1'b0;
      pc_en      = 1'b1;
      pc_next    = RESET_VEC;
      flush      = 1'b0;
      misalign   = 1'b0;
    end else begin
      case (state_q)
        RESET: begin
          pc_en   = 1'b1;
          pc_next = RESET_VEC;
          state_d = FETCH;
        end
        FETCH, WAIT: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            pend_vld_d = 1'b0;
            if (eff_redirect) begin
              pc_en   = 1'b1;
              pc_next = eff_target;
              state_d = FETCH;
            end else if (stall) begin
              state_d = HOLD;
            end else begin
              fetch_valid = 1'b1;
              pc_en       = 1'b1;
              state_d     = FETCH;
            end
          end else begin
            state_d = WAIT;
            if (sel_redirect && (!pend_vld_q || (sel_rank >= pend_rank_q))) begin
              pend_vld_d  = 1'b1;
              pend_tgt_d  = sel_target;
              pend_rank_d = sel_rank;
            end else begin
              pend_vld_d = pend_vld_q;
            end
          end
        end
        HOLD: begin
          if (sel_redirect) begin
            pc_en   = 1'b1;
            pc_next = sel_target;
            state_d = FETCH;
          end else if (!stall) begin
            fetch_valid = 1'b1;
            pc_en       = 1'b1;
            state_d     = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        default: begin
          pc_en   = 1'b1;
          pc_next = RESET_VEC;
          state_d = RESET;
        end
      endcase
    end
  end

  // State and pending-redirect registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    pend_vld_q  <= pend_vld_d;
    pend_tgt_q  <= pend_tgt_d;
    pend_rank_q <= pend_rank_d;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized
// traffic against a flag-based behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam logic [31:0] TRP_V = 32'h0000_0010;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_cur = 32'hDEAD_BEEC;
  logic        pc_en, imem_req, fetch_valid, flush, misalign;
  logic [31:0] pc_next;
  logic        imem_ack = 1'b0, stall = 1'b0, br_taken = 1'b0, jmp = 1'b0, trap = 1'b0;
  logic [31:0] br_target = 32'h0, jmp_target = 32'h0;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ctrl dut (
    .clk(clk), .rst(rst), .pc_cur(pc_cur), .pc_en(pc_en), .pc_next(pc_next),
    .imem_req(imem_req), .imem_ack(imem_ack), .stall(stall),
    .br_taken(br_taken), .br_target(br_target), .jmp(jmp), .jmp_target(jmp_target),
    .trap(trap), .fetch_valid(fetch_valid), .flush(flush), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Program counter register that the controller drives.
  always @(posedge clk) if (pc_en) pc_cur <= pc_next;

  // ---------------- behavioural model ----------------
  typedef struct { int rank; logic [31:0] tgt; bit mis; } redir_t;
  typedef struct { bit req; bit en; bit fv; bit fl; bit mis; logic [31:0] nxt; } exp_t;

  bit          m_resetting = 1'b0, m_waiting = 1'b0, m_holding = 1'b0, m_pend = 1'b0;
  logic [31:0] m_pend_tgt = 32'h0;
  int          m_pend_rank = 0;

  function automatic redir_t cur_redirect();
    redir_t r;
    r.rank = 0; r.tgt = TRP_V; r.mis = 1'b0;
    if (trap) r.rank = 3;
    else if (jmp) begin
      if (jmp_target % 4 != 0) begin r.rank = 3; r.mis = 1'b1; end
      else begin r.rank = 2; r.tgt = jmp_target; end
    end else if (br_taken) begin
      if (br_target % 4 != 0) begin r.rank = 3; r.mis = 1'b1; end
      else begin r.rank = 1; r.tgt = br_target; end
    end
    return r;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    redir_t r = cur_redirect();
    e.req = 0; e.en = 0; e.fv = 0; e.fl = 0; e.mis = 0; e.nxt = 32'h0;
    if (rst) begin
      e.en = 1; e.nxt = RST_V;
    end else begin
      e.fl = (r.rank > 0); e.mis = r.mis;
      if (m_resetting) begin
        e.en = 1; e.nxt = RST_V;
      end else if (m_holding) begin
        if (r.rank > 0) begin e.en = 1; e.nxt = r.tgt; end
        else if (!stall) begin e.en = 1; e.fv = 1; e.nxt = pc_cur + 32'd4; end
      end else begin
        e.req = 1;
        if (imem_ack) begin
          if (m_waiting && m_pend && (r.rank == 0 || m_pend_rank > r.rank)) begin
            e.en = 1; e.nxt = m_pend_tgt;
          end else if (r.rank > 0) begin
            e.en = 1; e.nxt = r.tgt;
          end else if (!stall) begin
            e.en = 1; e.fv = 1; e.nxt = pc_cur + 32'd4;
          end
        end
      end
    end
    return e;
  endfunction

  always @(posedge clk) begin : model_update
    redir_t r;
    bit redirect_now;
    r = cur_redirect();
    redirect_now = (r.rank > 0) || (m_waiting && m_pend);
    if (rst) begin
      m_resetting <= 1; m_waiting <= 0; m_holding <= 0; m_pend <= 0;
    end else if (m_resetting) begin
      m_resetting <= 0;
    end else if (m_holding) begin
      if (r.rank > 0 || !stall) m_holding <= 0;
    end else if (imem_ack) begin
      m_waiting <= 0; m_pend <= 0;
      if (!redirect_now && stall) m_holding <= 1;
    end else begin
      m_waiting <= 1;
      if (r.rank > 0 && (!m_pend || r.rank >= m_pend_rank)) begin
        m_pend <= 1; m_pend_tgt <= r.tgt; m_pend_rank <= r.rank;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    imem_ack = 0; stall = 0; br_taken = 0; jmp = 0; trap = 0;
    br_target = 32'h0; jmp_target = 32'h0;
  endtask

  task automatic do_reset();
    next_cycle(); clear_in(); rst = 1;
    next_cycle();
    next_cycle(); rst = 0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_in(); rst = 1; imem_ack = 1; br_taken = 1; br_target = 32'h40;
    next_cycle(); next_cycle(); @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b01000) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b01000); end
    n_checks++; if (pc_next !== RST_V) begin n_fail++; $display("FAIL reset_pc_next: got %h want %h", pc_next, RST_V); end
    next_cycle(); rst = 0; clear_in(); @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b01000) begin n_fail++; $display("FAIL reset_state_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b01000); end
    n_checks++; if (pc_next !== RST_V) begin n_fail++; $display("FAIL reset_state_pc: got %h want %h", pc_next, RST_V); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
      n_checks++; if (pc_cur !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_pc[%0d]: got %h want %h", i, pc_cur, 32'(4 * i)); end
      n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b11100) begin n_fail++; $display("FAIL seq_ctl[%0d]: got %b want %b", i, {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b11100); end
      n_checks++; if (pc_next !== 32'(4 * i + 4)) begin n_fail++; $display("FAIL seq_next[%0d]: got %h want %h", i, pc_next, 32'(4 * i + 4)); end
    end
  endtask

  task automatic test_branch();
    do_reset();
    next_cycle(); clear_in(); imem_ack = 1;
    next_cycle(); clear_in(); imem_ack = 1;
    next_cycle(); clear_in(); imem_ack = 1; br_taken = 1; br_target = 32'h40; @(negedge clk);
    n_checks++; if (pc_cur !== 32'h8) begin n_fail++; $display("FAIL br_pc: got %h want %h", pc_cur, 32'h8); end
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b11010) begin n_fail++; $display("FAIL br_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b11010); end
    n_checks++; if (pc_next !== 32'h40) begin n_fail++; $display("FAIL br_next: got %h want %h", pc_next, 32'h40); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if (pc_cur !== 32'h40) begin n_fail++; $display("FAIL br_target_pc: got %h want %h", pc_cur, 32'h40); end
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b11100) begin n_fail++; $display("FAIL br_after_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b11100); end
  endtask

  task automatic test_wait_redirect();
    do_reset();
    next_cycle(); clear_in(); @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b10000) begin n_fail++; $display("FAIL wait_req_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b10000); end
    next_cycle(); clear_in(); jmp = 1; jmp_target = 32'h80; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b10010) begin n_fail++; $display("FAIL wait_jmp_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b10010); end
    next_cycle(); clear_in(); trap = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b10010) begin n_fail++; $display("FAIL wait_trap_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b10010); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b11000) begin n_fail++; $display("FAIL wait_ack_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b11000); end
    n_checks++; if (pc_next !== TRP_V) begin n_fail++; $display("FAIL wait_ack_next: got %h want %h", pc_next, TRP_V); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if ({pc_cur, fetch_valid} !== {TRP_V, 1'b1}) begin n_fail++; $display("FAIL wait_after: got %h/%b want %h/1", pc_cur, fetch_valid, TRP_V); end
  endtask

  task automatic test_stall();
    do_reset();
    next_cycle(); clear_in(); imem_ack = 1;
    next_cycle(); clear_in(); imem_ack = 1; stall = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b10000) begin n_fail++; $display("FAIL stall_ack_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b10000); end
    next_cycle(); clear_in(); imem_ack = 1; stall = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b00000) begin n_fail++; $display("FAIL hold_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b00000); end
    n_checks++; if (pc_cur !== 32'h4) begin n_fail++; $display("FAIL hold_pc: got %h want %h", pc_cur, 32'h4); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b01100) begin n_fail++; $display("FAIL release_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b01100); end
    n_checks++; if (pc_next !== 32'h8) begin n_fail++; $display("FAIL release_next: got %h want %h", pc_next, 32'h8); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if ({pc_cur, imem_req} !== {32'h8, 1'b1}) begin n_fail++; $display("FAIL release_after: got %h/%b want %h/1", pc_cur, imem_req, 32'h8); end
  endtask

  task automatic test_misalign();
    do_reset();
    next_cycle(); clear_in(); imem_ack = 1; jmp = 1; jmp_target = 32'h82; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== 5'b11011) begin n_fail++; $display("FAIL mis_ctl: got %b want %b", {imem_req, pc_en, fetch_valid, flush, misalign}, 5'b11011); end
    n_checks++; if (pc_next !== TRP_V) begin n_fail++; $display("FAIL mis_next: got %h want %h", pc_next, TRP_V); end
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if ({pc_cur, misalign} !== {TRP_V, 1'b0}) begin n_fail++; $display("FAIL mis_after: got %h/%b want %h/0", pc_cur, misalign, TRP_V); end
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    next_cycle(); clear_in();
    next_cycle(); clear_in();
    next_cycle(); clear_in(); rst = 1; imem_ack = 1; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign, pc_next} !== {5'b01000, RST_V}) begin n_fail++; $display("FAIL rstwait_rst: got %b/%h want 01000/%h", {imem_req, pc_en, fetch_valid, flush, misalign}, pc_next, RST_V); end
    next_cycle(); rst = 0; @(negedge clk);
    n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign, pc_next} !== {5'b01000, RST_V}) begin n_fail++; $display("FAIL rstwait_reset: got %b/%h want 01000/%h", {imem_req, pc_en, fetch_valid, flush, misalign}, pc_next, RST_V); end
    next_cycle(); @(negedge clk);
    n_checks++; if ({pc_cur, imem_req, fetch_valid, pc_next} !== {RST_V, 1'b1, 1'b1, 32'h4}) begin n_fail++; $display("FAIL rstwait_fetch: got %h/%b/%b/%h want %h/1/1/4", pc_cur, imem_req, fetch_valid, pc_next, RST_V); end
  endtask

  task automatic test_wrap();
    do_reset();
    next_cycle(); clear_in(); imem_ack = 1; br_taken = 1; br_target = 32'hFFFF_FFFC;
    next_cycle(); clear_in(); imem_ack = 1; @(negedge clk);
    n_checks++; if (pc_cur !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pc: got %h want %h", pc_cur, 32'hFFFF_FFFC); end
    n_checks++; if ({fetch_valid, pc_en, pc_next} !== {1'b1, 1'b1, 32'h0}) begin n_fail++; $display("FAIL wrap_next: got %b/%b/%h want 1/1/00000000", fetch_valid, pc_en, pc_next); end
  endtask

  task automatic test_random();
    exp_t e;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      rst        = ($urandom_range(0, 99) == 0);
      imem_ack   = ($urandom_range(0, 9) < 6);
      stall      = ($urandom_range(0, 9) < 2);
      br_taken   = ($urandom_range(0, 9) == 0);
      jmp        = ($urandom_range(0, 14) == 0);
      trap       = ($urandom_range(0, 32) == 0);
      br_target  = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      jmp_target = ($urandom_range(0, 3) == 0) ? $urandom() : ($urandom() & 32'hFFFF_FFFC);
      @(negedge clk);
      e = model_expect();
      n_checks++; if ({imem_req, pc_en, fetch_valid, flush, misalign} !== {e.req, e.en, e.fv, e.fl, e.mis}) begin n_fail++; $display("FAIL rand_ctl[%0d]: got %b want %b", cyc, {imem_req, pc_en, fetch_valid, flush, misalign}, {e.req, e.en, e.fv, e.fl, e.mis}); end
      if (e.en) begin
        n_checks++; if (pc_next !== e.nxt) begin n_fail++; $display("FAIL rand_next[%0d]: got %h want %h", cyc, pc_next, e.nxt); end
      end
    end
    clear_in(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_wait_redirect();
    test_stall();
    test_misalign();
    test_rst_in_wait();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
